// File: rtl/pipe_alu_unit.sv
// Pipelined execution unit: single-cycle ALU feeding a STAGES-deep register pipeline
// with valid/ready handshake, flush, and an in-flight destination hazard query.
module pipe_alu_unit #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAGW   = 5,
    parameter int IMMW   = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [IMMW-1:0] in_imm,
    input  logic [TAGW-1:0] in_rd,
    input  logic            in_we,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [TAGW-1:0] out_rd,
    output logic            out_we,
    output logic            out_illegal,
    input  logic [TAGW-1:0] qa_rs,
    input  logic [TAGW-1:0] qb_rs,
    output logic            qa_hit,
    output logic            qb_hit
);

    localparam int SHW = $clog2(XLEN);

    logic              advance;
    logic [XLEN-1:0]   imm_ext;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   alu_result;
    logic              alu_illegal;

    logic [STAGES-1:0] st_valid;
    logic [STAGES-1:0] st_we;
    logic [STAGES-1:0] st_ill;
    logic [TAGW-1:0]   st_rd  [STAGES];
    logic [XLEN-1:0]   st_res [STAGES];

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !flush && !reset;
    assign imm_ext  = XLEN'($signed(in_imm));
    assign shamt    = in_b[SHW-1:0];

    always_comb begin
        alu_result  = '0;
        alu_illegal = 1'b0;
        case (in_op)
            4'd0:    alu_result = in_a + in_b;
            4'd1:    alu_result = in_a + imm_ext;
            4'd2:    alu_result = in_a << shamt;
            4'd3:    alu_result = in_a - in_b;
            4'd4:    alu_result = in_a >> shamt;
            4'd5:    alu_result = $unsigned($signed(in_a) >>> shamt);
            4'd6:    alu_result = in_a & in_b;
            4'd7:    alu_result = in_a | in_b;
            4'd8:    alu_result = in_a ^ in_b;
            default: alu_illegal = 1'b1;
        endcase
    end

    // Stage payloads load even for bubbles; only the valid bit gives them meaning.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_valid <= '0;
            st_we    <= '0;
            st_ill   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                st_rd[i]  <= '0;
                st_res[i] <= '0;
            end
        end else if (flush) begin
            st_valid <= '0;
        end else if (advance) begin
            st_valid[0] <= in_valid && in_ready;
            st_we[0]    <= in_we && !alu_illegal;
            st_ill[0]   <= alu_illegal;
            st_rd[0]    <= in_rd;
            st_res[0]   <= alu_result;
            for (int i = 1; i < STAGES; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_we[i]    <= st_we[i-1];
                st_ill[i]   <= st_ill[i-1];
                st_rd[i]    <= st_rd[i-1];
                st_res[i]   <= st_res[i-1];
            end
        end
    end

    always_comb begin
        qa_hit = 1'b0;
        qb_hit = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (st_valid[i] && st_we[i] && (st_rd[i] != '0)) begin
                if (st_rd[i] == qa_rs) qa_hit = 1'b1;
                if (st_rd[i] == qb_rs) qb_hit = 1'b1;
            end
        end
    end

    assign out_valid   = st_valid[STAGES-1];
    assign out_result  = st_res[STAGES-1];
    assign out_rd      = st_rd[STAGES-1];
    assign out_we      = st_we[STAGES-1];
    assign out_illegal = st_ill[STAGES-1];

endmodule

// File: tb/tb_pipe_alu_unit.sv
// Bench for pipe_alu_unit: directed vector table, hand-written stall/flush/hazard/reset
// sequences, and randomized traffic scored against a queue-based reference model.
module tb_pipe_alu_unit;

    localparam int XLEN   = 32;
    localparam int STAGES = 2;
    localparam int TAGW   = 5;
    localparam int IMMW   = 12;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [IMMW-1:0] in_imm;
    logic [TAGW-1:0] in_rd;
    logic            in_we;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [TAGW-1:0] out_rd;
    logic            out_we;
    logic            out_illegal;
    logic [TAGW-1:0] qa_rs;
    logic [TAGW-1:0] qb_rs;
    logic            qa_hit;
    logic            qb_hit;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [IMMW-1:0] imm;
        logic [TAGW-1:0] rd;
        logic            we;
        logic [XLEN-1:0] exp_res;
        logic            exp_we;
        logic            exp_ill;
    } vec_t;

    typedef struct {
        logic [XLEN-1:0] res;
        logic [TAGW-1:0] rd;
        logic            we;
        logic            ill;
    } res_t;

    vec_t vecs[10];
    res_t expq[$];

    pipe_alu_unit #(.XLEN(XLEN), .STAGES(STAGES), .TAGW(TAGW), .IMMW(IMMW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_rd(in_rd), .in_we(in_we),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal),
        .qa_rs(qa_rs), .qb_rs(qb_rs), .qa_hit(qa_hit), .qb_hit(qb_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    // Reference ALU straight from the opcode table.
    function automatic res_t model(input logic [3:0] op, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b, input logic [IMMW-1:0] imm,
                                   input logic [TAGW-1:0] rd, input logic we);
        res_t r;
        int unsigned sh;
        sh    = b % XLEN;
        r.rd  = rd;
        r.ill = 1'b0;
        r.res = '0;
        case (op)
            4'd0: r.res = a + b;
            4'd1: r.res = a + XLEN'($signed(imm));
            4'd2: r.res = a << sh;
            4'd3: r.res = a - b;
            4'd4: r.res = a >> sh;
            4'd5: r.res = $unsigned($signed(a) >>> sh);
            4'd6: r.res = a & b;
            4'd7: r.res = a | b;
            4'd8: r.res = a ^ b;
            default: r.ill = 1'b1;
        endcase
        r.we = we && !r.ill;
        return r;
    endfunction

    function automatic logic modelHit(input logic [TAGW-1:0] q);
        foreach (expq[i])
            if (expq[i].we && expq[i].rd != '0 && expq[i].rd == q) return 1'b1;
        return 1'b0;
    endfunction

    task automatic applyStimulus(input vec_t v);
        in_op  = v.op;
        in_a   = v.a;
        in_b   = v.b;
        in_imm = v.imm;
        in_rd  = v.rd;
        in_we  = v.we;
        in_valid = 1'b1;
    endtask

    task automatic checkOutput(input string name, input vec_t v);
        check({name, ".valid"},   out_valid,   1'b1);
        check({name, ".result"},  out_result,  v.exp_res);
        check({name, ".rd"},      out_rd,      v.rd);
        check({name, ".we"},      out_we,      v.exp_we);
        check({name, ".illegal"}, out_illegal, v.exp_ill);
    endtask

    initial begin
        int lat;
        int k;
        vec_t v;
        res_t r;
        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_imm = '0;
        in_rd = '0; in_we = 1'b0; flush = 1'b0; out_ready = 1'b1; qa_rs = '0; qb_rs = '0;

        vecs[0] = '{4'd0, 32'd5,          32'd7,          12'h000, 5'd3, 1'b1, 32'd12,         1'b1, 1'b0};
        vecs[1] = '{4'd1, 32'd10,         32'd0,          12'hFFF, 5'd4, 1'b1, 32'd9,          1'b1, 1'b0};
        vecs[2] = '{4'd3, 32'd3,          32'd5,          12'h000, 5'd5, 1'b1, 32'hFFFFFFFE,   1'b1, 1'b0};
        vecs[3] = '{4'd5, 32'h80000000,   32'd4,          12'h000, 5'd6, 1'b1, 32'hF8000000,   1'b1, 1'b0};
        vecs[4] = '{4'd2, 32'd1,          32'd33,         12'h000, 5'd7, 1'b1, 32'd2,          1'b1, 1'b0};
        vecs[5] = '{4'd4, 32'h80000000,   32'd31,         12'h000, 5'd8, 1'b0, 32'd1,          1'b0, 1'b0};
        vecs[6] = '{4'd6, 32'hF0F000FF,   32'h0FF00F0F,   12'h000, 5'd9, 1'b1, 32'h00F0000F,   1'b1, 1'b0};
        vecs[7] = '{4'd7, 32'h000000F0,   32'h0F00000F,   12'h000, 5'd0, 1'b1, 32'h0F0000FF,   1'b1, 1'b0};
        vecs[8] = '{4'd8, 32'hFFFF0000,   32'hFF00FF00,   12'h000, 5'd2, 1'b1, 32'h00FFFF00,   1'b1, 1'b0};
        vecs[9] = '{4'd15, 32'd1,         32'd1,          12'h000, 5'd4, 1'b1, 32'd0,          1'b0, 1'b1};

        // Reset state
        nextCycle(); nextCycle(); #1;
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.out_result", out_result, '0);
        check("rst.out_rd", out_rd, '0);
        check("rst.out_we", out_we, 1'b0);
        check("rst.out_illegal", out_illegal, 1'b0);
        check("rst.in_ready", in_ready, 1'b0);
        check("rst.hits", {qa_hit, qb_hit}, 2'b00);
        nextCycle(); reset = 1'b0; #1;
        check("rst.in_ready_after", in_ready, 1'b1);

        // Directed vectors, one at a time, with latency and stage-1 hazard check
        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            nextCycle(); applyStimulus(v); qa_rs = v.rd; #1;
            check($sformatf("vec%0d.in_ready", i), in_ready, 1'b1);
            nextCycle(); in_valid = 1'b0; lat = 1; #1;
            check($sformatf("vec%0d.hazard", i), qa_hit, v.exp_we && (v.rd != 0));
            while (!out_valid && lat < 10) begin
                nextCycle(); #1; lat++;
            end
            check($sformatf("vec%0d.latency", i), lat, STAGES);
            checkOutput($sformatf("vec%0d", i), v);
        end
        nextCycle(); #1;
        check("vec.drained", out_valid, 1'b0);

        // Ten back-to-back ADDs leave on ten consecutive cycles
        k = 0;
        for (int c = 0; c < 14; c++) begin
            nextCycle();
            in_valid = (c < 10); in_op = 4'd0; in_a = c; in_b = c + 1; in_rd = 5'(c % 8 + 1); in_we = 1'b1;
            #1;
            check($sformatf("b2b.valid%0d", c), out_valid, (c >= STAGES) && (c < STAGES + 10));
            if (out_valid) begin
                check($sformatf("b2b.result%0d", k), out_result, 2 * k + 1);
                k++;
            end
        end

        // Back-pressure: A and B held while out_ready is low
        nextCycle(); out_ready = 1'b0; in_valid = 1'b1; in_op = 4'd0; in_a = 1; in_b = 1; in_rd = 5'd1; in_we = 1'b1;
        nextCycle(); in_a = 2; in_b = 2; in_rd = 5'd2;
        nextCycle(); in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall.valid", out_valid, 1'b1);
            check("stall.rd", out_rd, 5'd1);
            check("stall.result", out_result, 32'd2);
            check("stall.in_ready", in_ready, 1'b0);
            nextCycle();
        end
        out_ready = 1'b1; #1;
        check("stall.relA", {out_valid, out_rd, out_result}, {1'b1, 5'd1, 32'd2});
        nextCycle(); #1;
        check("stall.relB", {out_valid, out_rd, out_result}, {1'b1, 5'd2, 32'd4});
        nextCycle(); #1;
        check("stall.empty", out_valid, 1'b0);

        // Flush with two ops in flight and a concurrent offer
        qa_rs = 5'd6; qb_rs = 5'd7;
        nextCycle(); in_valid = 1'b1; in_rd = 5'd6;
        nextCycle(); in_rd = 5'd7;
        nextCycle(); in_rd = 5'd9; flush = 1'b1; #1;
        check("flush.pre_hits", {qa_hit, qb_hit}, 2'b11);
        check("flush.in_ready", in_ready, 1'b0);
        nextCycle(); flush = 1'b0; in_valid = 1'b0; #1;
        check("flush.valid", out_valid, 1'b0);
        check("flush.hits", {qa_hit, qb_hit}, 2'b00);
        nextCycle(); #1;
        check("flush.not_accepted", out_valid, 1'b0);

        // Hazard lifetime, register 0, and reset mid-stream
        nextCycle(); in_valid = 1'b1; in_rd = 5'd3; in_we = 1'b1; qa_rs = 5'd3; #1;
        check("haz.before", qa_hit, 1'b0);
        nextCycle(); in_valid = 1'b0; #1;
        check("haz.stage1", qa_hit, 1'b1);
        nextCycle(); #1;
        check("haz.out_stage", qa_hit, 1'b1);
        nextCycle(); #1;
        check("haz.consumed", qa_hit, 1'b0);
        nextCycle(); in_valid = 1'b1; in_rd = 5'd0; qa_rs = 5'd0;
        nextCycle(); in_valid = 1'b0; #1;
        check("haz.reg0", qa_hit, 1'b0);
        nextCycle(); in_valid = 1'b1; in_a = 32'h55; in_rd = 5'd5; qa_rs = 5'd5;
        nextCycle();
        nextCycle(); reset = 1'b1; #1;
        check("rst2.in_ready", in_ready, 1'b0);
        nextCycle(); reset = 1'b0; in_valid = 1'b0; #1;
        check("rst2.outs", {out_valid, out_result, out_rd, out_we, out_illegal}, '0);
        check("rst2.hit", qa_hit, 1'b0);
        check("rst2.in_ready", in_ready, 1'b1);
        for (int c = 0; c < 4; c++) begin
            nextCycle(); #1;
            check("rst2.no_stale", out_valid, 1'b0);
        end

        // Randomized traffic against the queue model
        for (int c = 0; c < 400; c++) begin
            nextCycle();
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 32) == 0;
            in_op     = (($urandom % 8) == 0) ? 4'(9 + $urandom % 7) : 4'($urandom % 9);
            in_a      = $urandom;
            in_b      = (($urandom % 2) == 0) ? 32'($urandom % 64) : $urandom;
            in_imm    = 12'($urandom);
            in_rd     = 5'($urandom % 8);
            in_we     = ($urandom % 4) != 0;
            qa_rs     = 5'($urandom % 8);
            qb_rs     = 5'($urandom % 8);
            #1;
            check("rnd.qa_hit", qa_hit, modelHit(qa_rs));
            check("rnd.qb_hit", qb_hit, modelHit(qb_rs));
            check("rnd.in_ready", in_ready, (!out_valid || out_ready) && !flush);
            if (out_valid) begin
                if (expq.size() == 0) check("rnd.spurious", 1'b1, 1'b0);
                else check("rnd.out", {out_result, out_rd, out_we, out_illegal},
                           {expq[0].res, expq[0].rd, expq[0].we, expq[0].ill});
            end
            if (flush) expq.delete();
            else begin
                if (out_valid && out_ready && expq.size() > 0) void'(expq.pop_front());
                if (in_valid && in_ready) begin
                    r = model(in_op, in_a, in_b, in_imm, in_rd, in_we);
                    expq.push_back(r);
                end
            end
        end
        nextCycle(); in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && expq.size() > 0; c++) begin
            #1;
            if (out_valid) begin
                check("drain.out", {out_result, out_rd, out_we, out_illegal},
                      {expq[0].res, expq[0].rd, expq[0].we, expq[0].ill});
                void'(expq.pop_front());
            end
            nextCycle();
        end
        check("drain.left", expq.size(), 0);
        #1;
        check("drain.valid", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
